key_expansion_ctrl: RTL and testbench
=====================================

Name: key_expansion_ctrl

Overview:
Sequences a single shared round-key generator instance iteratively to expand a 128-bit AES cipher key into the 11 round keys (round 0 to round 10). It issues one key and RCON word per round and waits for the generator's valid_out. It stores each result in an internal key store and exposes the store through a registered read port to the cipher round datapath. It sits between the AES top-level control and the round-key generator, with a watchdog on generator response.

Parameters:
KEY_L, 128, key and round-key width in bits
WORD, 32, word width; RCON word width
NR, 10, number of generated round keys (store depth NR+1)
TIMEOUT, 16, maximum cycles spent in WAIT before an error is flagged

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
start  input  1  begin expansion of key_in; sampled only in IDLE, DONE or ERROR
key_in  input  KEY_L  cipher key; sampled in the cycle start is accepted
busy  output  1  high while an expansion is in progress
done  output  1  single-cycle pulse when round key NR has been stored
key_ready  output  1  level; all NR+1 keys valid; cleared by start or error
err  output  1  level; watchdog expired; cleared by the next accepted start
rkg_valid_in  output  1  one-cycle request to the generator
rkg_key  output  KEY_L  previous round key presented to the generator
rkg_rcon  output  WORD  round constant word {rc, 24'h0}
rkg_round_key  input  KEY_L  generator result
rkg_valid_out  input  1  generator result valid
rk_rd_addr  input  4  key store read index 0..NR
rk_rd_data  output  KEY_L  registered read data

Behaviour:
- Reset (async, active-low): state IDLE; busy, done, key_ready, err, rkg_valid_in = 0; rkg_key, rkg_rcon, rk_rd_data = 0; round counter = 0; key store cleared to 0.
- FSM states are IDLE, ISSUE, WAIT, DONE and ERROR.
- IDLE/DONE/ERROR with start=1 (cycle T):
  - T+1: store[0] = key_in and cur_key = key_in.
  - round = 1; key_ready = 0 and err = 0.
  - State moves to ISSUE and busy = 1.
- ISSUE (one cycle):
  - rkg_valid_in = 1, rkg_key = cur_key, rkg_rcon = {rc(round), 24'h0}.
  - Next state is WAIT and the watchdog counter is cleared.
  - rkg_key and rkg_rcon hold their values through WAIT.
- rc sequence for round 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36. A table or xtime doubling with 0x1B reduction is acceptable.
- WAIT:
  - On rkg_valid_out=1, store[round] = rkg_round_key and cur_key = rkg_round_key.
  - If round == NR, go to DONE. Otherwise round is incremented and the FSM returns to ISSUE.
  - The watchdog counts every WAIT cycle without rkg_valid_out. When the count reaches TIMEOUT, go to ERROR: err = 1, busy = 0, key_ready = 0.
- DONE entry: done = 1 for exactly one cycle, key_ready = 1, busy = 0.
- ERROR: held until the next start; stored keys are not guaranteed.
- Timing with generator latency 4 (valid_in at cycle t gives valid_out at t+4): each round takes 5 cycles. start at T gives busy high T+1..T+50 and the done pulse at T+51.
- start while busy: ignored, with no restart and no effect on the store.
- rkg_valid_out in IDLE, ISSUE, DONE or ERROR: ignored and no store write.
- Read port:
  - rk_rd_data = store[rk_rd_addr] registered, 1-cycle latency.
  - rk_rd_addr > NR returns 0.
  - Reads during busy return current store contents; consumers qualify reads with key_ready.
  - A same-cycle write and read of one index returns the old contents.
- Reset mid-expansion: all state and outputs return to reset values immediately; no done pulse.

Test Plan:
1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start at T, generator latency 4:
   - store[1] = a0fafe1788542cb123a339392a6c7605 and store[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
   - done pulses at T+51 only; rkg_rcon sequence observed is 01000000..36000000.
2. start reasserted at cycles T+5 and T+30 during scenario 1: ignored, and results are identical to scenario 1.
3. Generator model never asserts rkg_valid_out: err = 1 and busy = 0 after 1 ISSUE + TIMEOUT (16) WAIT cycles. A new start clears err and completes normally.
4. reset pulsed low at T+20 of an expansion: all outputs are 0 asynchronously; store[0..10] read as 0; no done pulse; a subsequent start completes correctly.
5. Read port after completion: addr 0 returns key_in one cycle later; addr 10 returns the round-10 key; addr 11..15 return 0.
6. Spurious rkg_valid_out pulses injected in IDLE and in the ISSUE cycle: no store change, and the round counter advances only on WAIT responses.

Source files
------------

// File: rtl/key_expansion_ctrl.sv
// key_expansion_ctrl
//   Drives one shared AES round-key generator through rounds 1..NR, one request at a time.
//   Every result goes into an (NR+1)-entry key store. Entry 0 holds the cipher key.
//   The cipher datapath reads the store through a registered read port.
//   A watchdog moves the controller to ERROR if the generator stops answering.
//
// Ports
//   clk            system clock
//   reset          asynchronous active-low reset
//   start          begin expansion of key_in (accepted only in IDLE, DONE or ERROR)
//   key_in         cipher key, captured when start is accepted
//   busy           expansion in progress
//   done           one-cycle pulse when round key NR has been stored
//   key_ready      all NR+1 keys valid (level)
//   err            generator watchdog expired (level, cleared by next accepted start)
//   rkg_valid_in   one-cycle request to the generator
//   rkg_key        previous round key presented to the generator
//   rkg_rcon       round constant word {rc, 24'h0}
//   rkg_round_key  generator result
//   rkg_valid_out  generator result valid
//   rk_rd_addr     key store read index
//   rk_rd_data     registered read data (0 for indices above NR)

module key_expansion_ctrl #(
   parameter int unsigned KEY_L   = 128,
   parameter int unsigned WORD    = 32,
   parameter int unsigned NR      = 10,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [KEY_L-1:0] key_in,
   output logic             busy,
   output logic             done,
   output logic             key_ready,
   output logic             err,
   output logic             rkg_valid_in,
   output logic [KEY_L-1:0] rkg_key,
   output logic [WORD-1:0]  rkg_rcon,
   input  logic [KEY_L-1:0] rkg_round_key,
   input  logic             rkg_valid_out,
   input  logic [3:0]       rk_rd_addr,
   output logic [KEY_L-1:0] rk_rd_data
);

   localparam int unsigned    WdW       = $clog2(TIMEOUT + 1);
   localparam logic [3:0]     LastRound = 4'(NR);
   localparam logic [WdW-1:0] WdLast    = WdW'(TIMEOUT - 1);

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StError} state_e;

   state_e           state_q, state_d;
   logic [3:0]       round_q, round_d;
   logic [7:0]       rc_q, rc_d;
   logic [KEY_L-1:0] key_q, key_d;       // current (previous-round) key
   logic [WdW-1:0]   wd_q, wd_d;
   logic             done_q, done_d;
   logic             st_we;
   logic [3:0]       st_waddr;
   logic [KEY_L-1:0] st_wdata;
   logic [KEY_L-1:0] store_q [NR+1];
   logic [KEY_L-1:0] rd_q;

   // GF(2^8) doubling: walks the AES round-constant sequence 01, 02, ... 80, 1B, 36.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   always_comb begin
      state_d  = state_q;
      round_d  = round_q;
      rc_d     = rc_q;
      key_d    = key_q;
      wd_d     = wd_q;
      done_d   = 1'b0;
      st_we    = 1'b0;
      st_waddr = round_q;
      st_wdata = rkg_round_key;
      case (state_q)
         StIdle, StDone, StError: begin
            if (start) begin
               state_d  = StIssue;
               round_d  = 4'd1;
               rc_d     = 8'h01;
               key_d    = key_in;
               st_we    = 1'b1;
               st_waddr = 4'd0;
               st_wdata = key_in;
            end
         end
         StIssue: begin
            state_d = StWait;
            wd_d    = '0;
         end
         StWait: begin
            if (rkg_valid_out) begin
               st_we = 1'b1;
               key_d = rkg_round_key;
               if (round_q == LastRound) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end else begin
                  state_d = StIssue;
                  round_d = round_q + 4'd1;
                  rc_d    = xtime(rc_q);
               end
            end else if (wd_q == WdLast) begin
               state_d = StError;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         round_q <= '0;
         rc_q    <= '0;
         key_q   <= '0;
         wd_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         rc_q    <= rc_d;
         key_q   <= key_d;
         wd_q    <= wd_d;
         done_q  <= done_d;
      end
   end

   // A read in the same cycle as a write to the same index returns the old entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         store_q <= '{default: '0};
         rd_q    <= '0;
      end else begin
         if (st_we) begin
            store_q[st_waddr] <= st_wdata;
         end
         rd_q <= (rk_rd_addr <= LastRound) ? store_q[rk_rd_addr] : '0;
      end
   end

   assign busy         = (state_q == StIssue) || (state_q == StWait);
   assign key_ready    = (state_q == StDone);
   assign err          = (state_q == StError);
   assign rkg_valid_in = (state_q == StIssue);
   assign done         = done_q;
   assign rkg_key      = key_q;
   assign rkg_rcon     = {rc_q, {(WORD - 8){1'b0}}};
   assign rk_rd_data   = rd_q;

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Bench for key_expansion_ctrl. It models the round-key generator as a real AES key-schedule
// step with latency 4 and compares the key store against an independent key expansion.
module tb_key_expansion_ctrl;

   localparam int TIMEOUT = 16;
   localparam logic [7:0] RC [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   logic         clk, reset, start;
   logic [127:0] key_in;
   logic         busy, done, key_ready, err, rkg_valid_in;
   logic [127:0] rkg_key;
   logic [31:0]  rkg_rcon;
   logic [127:0] rkg_round_key;
   logic         rkg_valid_out;
   logic [3:0]   rk_rd_addr;
   logic [127:0] rk_rd_data;

   int n_tests = 0;
   int n_fail  = 0;

   bit           gen_en = 1'b1;
   int           inj_req = 0;
   int           inj_ack;
   int           gen_cnt;
   logic [127:0] gen_res;
   logic [31:0]  rcon_log [$];
   logic [127:0] gkey_log [$];
   logic [127:0] last_exp [16];

   logic [127:0] fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   logic [127:0] fips_r1  = 128'ha0fafe1788542cb123a339392a6c7605;
   logic [127:0] fips_r10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   key_expansion_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .key_in        (key_in),
      .busy          (busy),
      .done          (done),
      .key_ready     (key_ready),
      .err           (err),
      .rkg_valid_in  (rkg_valid_in),
      .rkg_key       (rkg_key),
      .rkg_rcon      (rkg_rcon),
      .rkg_round_key (rkg_round_key),
      .rkg_valid_out (rkg_valid_out),
      .rk_rd_addr    (rk_rd_addr),
      .rk_rd_data    (rk_rd_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- AES key schedule reference ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'h00;
      for (int i = 1; i < 256; i++) if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] aes_next(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w3, rot, t, n0, n1, n2, n3;
      w3  = k[31:0];
      rot = {w3[23:0], w3[31:24]};
      t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
      n0  = k[127:96] ^ t;
      n1  = k[95:64] ^ n0;
      n2  = k[63:32] ^ n1;
      n3  = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- generator model: latency 4, optional spurious pulses ----------------
   initial begin
      rkg_valid_out = 1'b0;
      rkg_round_key = '0;
      inj_ack       = 0;
      gen_cnt       = 0;
      gen_res       = '0;
      forever begin
         @(posedge clk);
         #1;
         rkg_valid_out = 1'b0;
         if (!reset) gen_cnt = 0;
         if (inj_req != inj_ack) begin
            inj_ack       = inj_req;
            rkg_valid_out = 1'b1;
            rkg_round_key = rand128();
         end
         if (gen_cnt > 0) begin
            gen_cnt--;
            if (gen_cnt == 0) begin
               rkg_valid_out = 1'b1;
               rkg_round_key = gen_res;
            end
         end
         if (reset && gen_en && rkg_valid_in) begin
            gen_cnt = 4;
            gen_res = aes_next(rkg_key, rkg_rcon[31:24]);
            rcon_log.push_back(rkg_rcon);
            gkey_log.push_back(rkg_key);
         end
      end
   end

   task automatic read_store(input int a, output logic [127:0] d);
      @(negedge clk);
      rk_rd_addr = 4'(a);
      @(negedge clk);
      d = rk_rd_data;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [127:0] d;
      logic [7:0]   outs;
      #1;
      outs = {busy, done, key_ready, err, rkg_valid_in, |rkg_key, |rkg_rcon, |rk_rd_data};
      n_tests++;
      if (outs !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b, want 00000000", outs);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int a = 0; a <= 10; a += 5) begin
         read_store(a, d);
         n_tests++;
         if (d !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_store[%0d]: got %h, want 0", a, d);
         end
      end
   endtask

   task automatic test_spurious_idle();
      logic [127:0] d;
      inj_req++;
      repeat (3) @(negedge clk);
      inj_req++;
      repeat (3) @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL spur_idle_busy: got %b, want 0", busy);
      end
      for (int a = 0; a <= 10; a++) begin
         read_store(a, d);
         n_tests++;
         if (d !== 128'h0) begin
            n_fail++;
            $display("FAIL spur_idle_store[%0d]: got %h, want 0", a, d);
         end
      end
   endtask

   task automatic test_expansion(input string name, input logic [127:0] key, input int re1,
                                 input int re2, input bit spur);
      logic [127:0] exp_k [16];
      logic [127:0] d;
      int           base, busy_bad, done_bad, err_bad, bad_i;
      logic         busy_v, done_v;
      exp_k[0] = key;
      for (int i = 1; i <= 10; i++) exp_k[i] = aes_next(exp_k[i-1], RC[i-1]);
      for (int i = 11; i < 16; i++) exp_k[i] = '0;
      base = rcon_log.size();
      @(negedge clk);
      start  = 1'b1;
      key_in = key;
      if (spur) inj_req++;
      busy_bad = 0; done_bad = 0; err_bad = 0; busy_v = 1'b0; done_v = 1'b0;
      for (int k = 1; k <= 56; k++) begin
         @(negedge clk);
         start  = (k == re1) || (k == re2);
         key_in = start ? ~key : key;
         if (busy !== (k <= 50) && busy_bad == 0) begin busy_bad = k; busy_v = busy; end
         if (done !== (k == 51) && done_bad == 0) begin done_bad = k; done_v = done; end
         if (err !== 1'b0 && err_bad == 0) err_bad = k;
      end
      start = 1'b0;
      n_tests++;
      if (busy_bad != 0) begin
         n_fail++;
         $display("FAIL %s busy_window: at T+%0d got %b, want %b", name, busy_bad, busy_v,
                  busy_bad <= 50);
      end
      n_tests++;
      if (done_bad != 0) begin
         n_fail++;
         $display("FAIL %s done_pulse: at T+%0d got %b, want %b", name, done_bad, done_v,
                  done_bad == 51);
      end
      n_tests++;
      if (err_bad != 0) begin
         n_fail++;
         $display("FAIL %s err_clear: err high at T+%0d, want 0", name, err_bad);
      end
      n_tests++;
      if (key_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s key_ready: got %b, want 1", name, key_ready);
      end
      n_tests++;
      bad_i = -1;
      if (rcon_log.size() == base + 10) begin
         for (int i = 0; i < 10; i++)
            if (rcon_log[base+i] !== {RC[i], 24'h0} && bad_i < 0) bad_i = i;
      end
      if (rcon_log.size() != base + 10) begin
         n_fail++;
         $display("FAIL %s rcon_count: got %0d requests, want 10", name, rcon_log.size() - base);
      end else if (bad_i >= 0) begin
         n_fail++;
         $display("FAIL %s rcon[%0d]: got %h, want %h", name, bad_i + 1, rcon_log[base+bad_i],
                  {RC[bad_i], 24'h0});
      end
      n_tests++;
      bad_i = -1;
      if (gkey_log.size() == base + 10) begin
         for (int i = 0; i < 10; i++) if (gkey_log[base+i] !== exp_k[i] && bad_i < 0) bad_i = i;
      end
      if (gkey_log.size() != base + 10) begin
         n_fail++;
         $display("FAIL %s rkg_key_count: got %0d, want 10", name, gkey_log.size() - base);
      end else if (bad_i >= 0) begin
         n_fail++;
         $display("FAIL %s rkg_key[%0d]: got %h, want %h", name, bad_i + 1,
                  gkey_log[base+bad_i], exp_k[bad_i]);
      end
      for (int a = 0; a < 16; a++) begin
         read_store(a, d);
         n_tests++;
         if (d !== exp_k[a]) begin
            n_fail++;
            $display("FAIL %s store[%0d]: got %h, want %h", name, a, d, exp_k[a]);
         end
      end
      last_exp = exp_k;
   endtask

   task automatic test_fips(input string name, input int re1, input int re2);
      logic [127:0] d;
      test_expansion(name, fips_key, re1, re2, 1'b0);
      read_store(1, d);
      n_tests++;
      if (d !== fips_r1) begin
         n_fail++;
         $display("FAIL %s fips_round1: got %h, want %h", name, d, fips_r1);
      end
      read_store(10, d);
      n_tests++;
      if (d !== fips_r10) begin
         n_fail++;
         $display("FAIL %s fips_round10: got %h, want %h", name, d, fips_r10);
      end
   endtask

   task automatic test_spurious_done();
      logic [127:0] d;
      int           done_seen;
      done_seen = 0;
      inj_req++;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (done === 1'b1) done_seen++;
      end
      inj_req++;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (done === 1'b1) done_seen++;
      end
      n_tests++;
      if (done_seen != 0 || key_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL spur_done_flags: got done=%0d key_ready=%b, want done=0 key_ready=1",
                  done_seen, key_ready);
      end
      for (int a = 0; a < 16; a++) begin
         read_store(a, d);
         n_tests++;
         if (d !== last_exp[a]) begin
            n_fail++;
            $display("FAIL spur_done_store[%0d]: got %h, want %h", a, d, last_exp[a]);
         end
      end
   endtask

   task automatic test_timeout();
      int busy_last, err_first;
      gen_en = 1'b0;
      @(negedge clk);
      start  = 1'b1;
      key_in = rand128();
      busy_last = 0; err_first = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy === 1'b1) busy_last = k;
         if (err === 1'b1 && err_first == 0) err_first = k;
      end
      n_tests++;
      if (busy_last != TIMEOUT + 1) begin
         n_fail++;
         $display("FAIL timeout_busy_last: got T+%0d, want T+%0d", busy_last, TIMEOUT + 1);
      end
      n_tests++;
      if (err_first != TIMEOUT + 2) begin
         n_fail++;
         $display("FAIL timeout_err_first: got T+%0d, want T+%0d", err_first, TIMEOUT + 2);
      end
      n_tests++;
      if (err !== 1'b1 || key_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_hold: got err=%b key_ready=%b, want err=1 key_ready=0",
                  err, key_ready);
      end
      gen_en = 1'b1;
      test_expansion("after_timeout", rand128(), 0, 0, 1'b0);
   endtask

   task automatic test_reset_mid();
      logic [127:0] d;
      logic [7:0]   outs;
      int           done_seen;
      @(negedge clk);
      rk_rd_addr = 4'd0;
      start      = 1'b1;
      key_in     = rand128();
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_busy_before: got %b, want 1", busy);
      end
      #2;
      reset = 1'b0;
      #1;
      outs = {busy, done, key_ready, err, rkg_valid_in, |rkg_key, |rkg_rcon, |rk_rd_data};
      n_tests++;
      if (outs !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_mid_async: got %b, want 00000000", outs);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      done_seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) done_seen++;
      end
      n_tests++;
      if (done_seen != 0) begin
         n_fail++;
         $display("FAIL reset_mid_quiet: got %0d cycles with done/busy, want 0", done_seen);
      end
      for (int a = 0; a <= 10; a++) begin
         read_store(a, d);
         n_tests++;
         if (d !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_mid_store[%0d]: got %h, want 0", a, d);
         end
      end
      test_expansion("after_reset", rand128(), 0, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++) test_expansion($sformatf("random%0d", r), rand128(), 0, 0, 1'b0);
   endtask

   initial begin
      reset      = 1'b0;
      start      = 1'b0;
      key_in     = '0;
      rk_rd_addr = '0;
      test_reset();
      test_spurious_idle();
      test_fips("fips", 0, 0);
      test_fips("restart_ignored", 5, 30);
      test_expansion("spur_issue", rand128(), 0, 0, 1'b1);
      test_spurious_done();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, want finish before 2000000");
      $fatal(1, "bench time limit");
   end

endmodule
